pea_top_module_1: RTL and testbench

Polynomial Evaluation Accelerator (PEA) core actor. Consumes 16-bit command words and 16-bit coefficient words from two external input FIFOs. Stores polynomials in eight internal coefficient slots and evaluates them. Each executed instruction produces one 32-bit result word and one 32-bit status word for two external output FIFOs. Firing is CFDF-style: the enclosing scheduler selects a mode, pulses `invoke`, and waits for `FC`.

---
 rtl/pea_top_module_1.sv | 244 ++++++++++++++++++++++++
 tb/tb_pea_top_module_1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pea_top_module_1.sv
// Polynomial Evaluation Accelerator core actor: stores up to eight polynomials and evaluates them by Horner's rule.
// Optional build macro PEA_OVERFLOW_DETECT_EN flags 32-bit accumulator overflow with status 4.
module pea_top_module_1 #(
  parameter int unsigned buffer_size = 1024,
  parameter int unsigned width       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [width-1:0]               data_in_fifo_command,
  input  logic [width-1:0]               data_in_fifo_data,
  input  logic                           invoke,
  input  logic [1:0]                     next_instr,
  input  logic [$clog2(buffer_size)-1:0] data_pop,
  input  logic [$clog2(buffer_size)-1:0] command_pop,
  output logic                           rd_in_command,
  output logic                           rd_in_data,
  output logic                           FC,
  output logic                           wr_out,
  output logic [31:0]                    data_out_result,
  output logic [31:0]                    data_out_status,
  output logic [7:0]                     instr,
  output logic [4:0]                     arg2
);

  localparam int unsigned PW    = $clog2(buffer_size);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned MACW  = 38;
  localparam logic [7:0]  OP_STP = 8'h01;
  localparam logic [7:0]  OP_EVP = 8'h02;
  localparam logic [7:0]  OP_CLR = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_GC_RD, S_GC_LATCH, S_STP_RD, S_STP_WR, S_EVP_LOOP, S_WRITE, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [2:0]      arg1_q, arg1_d;
  logic [4:0]      arg2_q, arg2_d;
  logic [7:0]      valid_q, valid_d;
  logic [7:0][4:0] deg_q, deg_d;
  logic [4:0]      idx_q, idx_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     status_q, status_d;
  logic            wr_q, wr_d, fc_q, fc_d, rdc_q, rdc_d, rdd_q, rdd_d;
  logic [width-1:0] rdata_q;
  logic            ram_we_c;
  logic [7:0]      ram_waddr_c, ram_raddr_c;
  logic [MACW-1:0] mac_c;
  logic            unused_cmd_pop;

  logic [width-1:0] ram [256];

  assign unused_cmd_pop = ^command_pop;

  // Horner step; product of a 32-bit acc and a 5-bit x plus a coefficient fits in 38 bits
  assign mac_c = MACW'(acc_q) * MACW'(arg2_q) + MACW'(rdata_q);

`ifdef PEA_OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;
`else
  logic unused_mac_hi;
  assign unused_mac_hi = ^mac_c[MACW-1:32];
`endif

  // Coefficient RAM with a registered read port
  always_ff @(posedge clk) begin
    if (ram_we_c) ram[ram_waddr_c] <= data_in_fifo_data;
    rdata_q <= ram[ram_raddr_c];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      arg1_q   <= '0;
      arg2_q   <= '0;
      valid_q  <= '0;
      deg_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      wr_q     <= 1'b0;
      fc_q     <= 1'b0;
      rdc_q    <= 1'b0;
      rdd_q    <= 1'b0;
`ifdef PEA_OVERFLOW_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      arg1_q   <= arg1_d;
      arg2_q   <= arg2_d;
      valid_q  <= valid_d;
      deg_q    <= deg_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      status_q <= status_d;
      wr_q     <= wr_d;
      fc_q     <= fc_d;
      rdc_q    <= rdc_d;
      rdd_q    <= rdd_d;
`ifdef PEA_OVERFLOW_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state and registered-output decode; every pulse is set on entry to the state that owns it
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    valid_d     = valid_q;
    deg_d       = deg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    status_d    = status_q;
    wr_d        = 1'b0;
    fc_d        = 1'b0;
    rdc_d       = 1'b0;
    rdd_d       = 1'b0;
    ram_we_c    = 1'b0;
    ram_waddr_c = {arg1_q, idx_q};
    ram_raddr_c = {arg1_q, idx_q};
`ifdef PEA_OVERFLOW_DETECT_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (invoke) begin
          case (next_instr)
            2'b00: begin
              state_d = S_GC_RD;
              rdc_d   = 1'b1;
            end
            2'b01: begin
              state_d  = S_WRITE;
              wr_d     = 1'b1;
              result_d = 32'd0;
              status_d = 32'd0;
              case (instr_q)
                OP_STP: begin
                  if (CW'(data_pop) >= CW'(arg2_q) + CW'(1)) begin
                    state_d = S_STP_RD;
                    wr_d    = 1'b0;
                    rdd_d   = 1'b1;
                    idx_d   = 5'd0;
                  end else begin
                    status_d = 32'd3;
                  end
                end
                OP_EVP: begin
                  if (valid_q[arg1_q]) begin
                    state_d     = S_EVP_LOOP;
                    wr_d        = 1'b0;
                    idx_d       = deg_q[arg1_q];
                    acc_d       = 32'd0;
                    ram_raddr_c = {arg1_q, deg_q[arg1_q]};
`ifdef PEA_OVERFLOW_DETECT_EN
                    ovf_d       = 1'b0;
`endif
                  end else begin
                    status_d = 32'd1;
                  end
                end
                OP_CLR:  valid_d[arg1_q] = 1'b0;
                default: status_d = 32'd2;
              endcase
            end
            default: begin
              state_d = S_DONE;
              fc_d    = 1'b1;
            end
          endcase
        end
      end
      S_GC_RD: state_d = S_GC_LATCH;
      S_GC_LATCH: begin
        instr_d = data_in_fifo_command[7:0];
        arg1_d  = data_in_fifo_command[10:8];
        arg2_d  = data_in_fifo_command[15:11];
        state_d = S_DONE;
        fc_d    = 1'b1;
      end
      S_STP_RD: state_d = S_STP_WR;
      S_STP_WR: begin
        ram_we_c = 1'b1;
        if (idx_q == arg2_q) begin
          valid_d[arg1_q] = 1'b1;
          deg_d[arg1_q]   = arg2_q;
          state_d  = S_WRITE;
          wr_d     = 1'b1;
          result_d = 32'd0;
          status_d = 32'd0;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_STP_RD;
          rdd_d   = 1'b1;
        end
      end
      S_EVP_LOOP: begin
        acc_d       = mac_c[31:0];
        idx_d       = idx_q - 5'd1;
        ram_raddr_c = {arg1_q, idx_q - 5'd1};
`ifdef PEA_OVERFLOW_DETECT_EN
        ovf_d       = ovf_q | (|mac_c[MACW-1:32]);
`endif
        if (idx_q == 5'd0) begin
          state_d  = S_WRITE;
          wr_d     = 1'b1;
          result_d = mac_c[31:0];
`ifdef PEA_OVERFLOW_DETECT_EN
          status_d = (ovf_q | (|mac_c[MACW-1:32])) ? 32'd4 : 32'd0;
`else
          status_d = 32'd0;
`endif
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        fc_d    = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_in_command   = rdc_q;
  assign rd_in_data      = rdd_q;
  assign FC              = fc_q;
  assign wr_out          = wr_q;
  assign data_out_result = result_q;
  assign data_out_status = status_q;
  assign instr           = instr_q;
  assign arg2            = arg2_q;

endmodule

// File: tb/tb_pea_top_module_1.sv
// Directed bench for pea_top_module_1: FIFO models, a reference Horner model and a result/status scoreboard.
module tb_pea_top_module_1;

`ifdef PEA_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        invoke = 1'b0;
  logic [1:0]  next_instr = 2'b00;
  logic [15:0] cmd_head = 16'h0;
  logic [15:0] dat_head = 16'h0;
  logic [9:0]  data_pop, command_pop;
  logic        rd_in_command, rd_in_data, FC, wr_out;
  logic [31:0] data_out_result, data_out_status;
  logic [7:0]  instr;
  logic [4:0]  arg2;

  logic [15:0] cmd_mem [64];
  logic [15:0] dmem [128];
  int cw = 0, cr = 0, dw = 0, dr = 0, mdr = 0;

  logic [31:0] obs_res [64];
  logic [31:0] obs_sts [64];
  int ow = 0, orp = 0, n_rdd = 0, n_rdc = 0;

  logic [63:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;

  bit          m_valid [8];
  logic [4:0]  m_deg [8];
  logic [15:0] m_coef [8][32];

  always #5 clk = ~clk;

  pea_top_module_1 dut (
    .clk(clk), .rst(rst_n),
    .data_in_fifo_command(cmd_head), .data_in_fifo_data(dat_head),
    .invoke(invoke), .next_instr(next_instr),
    .data_pop(data_pop), .command_pop(command_pop),
    .rd_in_command(rd_in_command), .rd_in_data(rd_in_data),
    .FC(FC), .wr_out(wr_out),
    .data_out_result(data_out_result), .data_out_status(data_out_status),
    .instr(instr), .arg2(arg2)
  );

  assign command_pop = 10'(cw - cr);
  assign data_pop    = 10'(dw - dr);

  // Input FIFOs with one-cycle read latency
  always @(posedge clk) begin
    if (rd_in_command) begin cmd_head <= cmd_mem[cr]; cr <= cr + 1; end
    if (rd_in_data)    begin dat_head <= dmem[dr];    dr <= dr + 1; end
  end

  // Output FIFO capture and pulse counters
  always @(negedge clk) begin
    if (wr_out) begin
      obs_res[ow] <= data_out_result;
      obs_sts[ow] <= data_out_status;
      ow <= ow + 1;
    end
    if (rd_in_data)    n_rdd <= n_rdd + 1;
    if (rd_in_command) n_rdc <= n_rdc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fire(input logic [1:0] mode, output int cyc);
    @(negedge clk);
    next_instr = mode;
    invoke = 1'b1;
    @(negedge clk);
    invoke = 1'b0;
    cyc = 1;
    while (!FC && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic gc(input logic [15:0] w);
    int cyc, rdc0;
    logic [15:0] wv;
    wv = w;
    cmd_mem[cw] = wv;
    cw++;
    rdc0 = n_rdc;
    fire(2'b00, cyc);
    check("gc_latency", 32'(cyc), 32'd3);
    check("gc_rd_pulses", 32'(n_rdc - rdc0), 32'd1);
    check("gc_instr", 32'(instr), 32'(wv[7:0]));
    check("gc_arg2", 32'(arg2), 32'(wv[15:11]));
  endtask

  task automatic exec(input logic [15:0] w);
    logic [7:0]  op;
    logic [2:0]  a1;
    logic [4:0]  n;
    logic [63:0] e, got;
    longint      acc;
    bit          ovf;
    int          ecyc, erdd, cyc, ow0, rdd0;
    logic [31:0] res, sts;
    op = w[7:0]; a1 = w[10:8]; n = w[15:11];
    res = 32'd0; sts = 32'd0; ecyc = 2; erdd = 0;
    gc(w);
    case (op)
      8'h01: begin
        if ((dw - mdr) >= int'(n) + 1) begin
          for (int i = 0; i <= int'(n); i++) m_coef[a1][i] = dmem[mdr + i];
          mdr += int'(n) + 1;
          m_valid[a1] = 1'b1;
          m_deg[a1] = n;
          ecyc = 2 * (int'(n) + 1) + 2;
          erdd = int'(n) + 1;
        end else sts = 32'd3;
      end
      8'h02: begin
        if (m_valid[a1]) begin
          acc = 0; ovf = 1'b0;
          for (int i = int'(m_deg[a1]); i >= 0; i--) begin
            acc = acc * longint'(n) + longint'(m_coef[a1][i]);
            if (acc > 64'hFFFF_FFFF) ovf = 1'b1;
            acc = acc & 64'hFFFF_FFFF;
          end
          res = acc[31:0];
          sts = (ovf && OVF_EN) ? 32'd4 : 32'd0;
          ecyc = int'(m_deg[a1]) + 3;
        end else sts = 32'd1;
      end
      8'h03: m_valid[a1] = 1'b0;
      default: sts = 32'd2;
    endcase
    exp_q.push_back({res, sts});
    ow0 = ow; rdd0 = n_rdd;
    fire(2'b01, cyc);
    check("instr_latency", 32'(cyc), 32'(ecyc));
    check("instr_wr_count", 32'(ow - ow0), 32'd1);
    check("instr_rd_data_count", 32'(n_rdd - rdd0), 32'(erdd));
    if (ow > orp) begin
      e = exp_q.pop_front();
      got = {obs_res[orp], obs_sts[orp]};
      orp++;
      check("result", got[63:32], e[63:32]);
      check("status", got[31:0], e[31:0]);
      check("result_held", data_out_result, e[63:32]);
    end
  endtask

  initial begin
    int cyc, ow0;
    for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_deg[s] = 5'd0; end
    repeat (2) @(negedge clk);
    check("rst_FC", 32'(FC), 32'd0);
    check("rst_wr_out", 32'(wr_out), 32'd0);
    check("rst_rd_cmd", 32'(rd_in_command), 32'd0);
    check("rst_rd_data", 32'(rd_in_data), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_arg2", 32'(arg2), 32'd0);
    check("rst_result", data_out_result, 32'd0);
    check("rst_status", data_out_status, 32'd0);
    rst_n = 1'b1;

    dmem[dw] = 16'd1; dw++;
    dmem[dw] = 16'd2; dw++;
    dmem[dw] = 16'd3; dw++;
    exec(16'h1001);
    exec(16'h1002);
    exec(16'h1802);
    exec(16'h0502);
    exec(16'h007F);

    dmem[dw] = 16'hFFFF; dw++;
    dmem[dw] = 16'hFFFF; dw++;
    exec(16'h2201);
    exec(16'h0901);
    exec(16'hF902);

    for (int i = 0; i < 32; i++) begin dmem[dw] = 16'hFFFF; dw++; end
    exec(16'hFB01);
    exec(16'hFB02);

    exec(16'h0003);
    exec(16'h1002);
    exec(16'h0903);

    ow0 = ow;
    fire(2'b10, cyc);
    check("output_latency", 32'(cyc), 32'd1);
    check("output_no_wr", 32'(ow - ow0), 32'd0);
    check("output_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
